voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice controller that shares a fixed pool of envelope-generator voices between incoming note events. It accepts note-on/note-off events over a valid/ready handshake, assigns each note to a voice, and drives per-voice gate, trigger and note outputs into the envelope and oscillator datapath. When all voices are busy it steals one. It returns a voice to the pool when that voice's envelope reports idle after release.

## Interface
- NUM_VOICES, 4, number of envelope voices managed (2..16)
- NOTE_WIDTH, 7, width of a note number
- AGE_WIDTH, 8, width of the per-voice saturating age counter
- Clock  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-low; clears all state when sampled 0
- EventValid  in  1  event present on EventOn/EventNote
- EventReady  out  1  allocator can accept an event
- EventOn  in  1  1 = note-on, 0 = note-off
- EventNote  in  NOTE_WIDTH  note number of the event
- EnvIdle  in  NUM_VOICES  bit i = voice i envelope has reached zero
- Gate  out  NUM_VOICES  bit i = voice i held (attack/decay/sustain)
- Trigger  out  NUM_VOICES  one-cycle pulse: voice i envelope restarts
- VoiceNote  out  NUM_VOICES*NOTE_WIDTH  note of voice i at bits [i*NOTE_WIDTH +: NOTE_WIDTH]
- Stolen  out  1  one-cycle pulse: a HELD voice was reassigned

## Operation
- Per-voice state: FREE, HELD, RELEASING. Gate[i] = 1 only in HELD.
- Controller FSM: IDLE (EventReady=1) -> EXEC on handshake (EventValid & EventReady). EventOn/EventNote are latched. EXEC (EventReady=0) applies the event and returns to IDLE.
- Note-on selection, first match wins:
  - HELD voice with same note (lowest index): retrigger. Gate stays 1, Trigger pulses, age cleared.
  - Lowest-index FREE voice.
  - RELEASING voice with largest age (tie: lowest index).
  - HELD voice with largest age (tie: lowest index). Stolen pulses.
- On any note-on assignment:
  - The voice goes to HELD and VoiceNote is loaded.
  - Trigger[i] pulses.
  - Age is cleared to 0.
- Note-off: the lowest-index HELD voice with matching note goes to RELEASING (Gate 0). VoiceNote is unchanged. If no voice matches, the event is consumed and ignored.
- RELEASING -> FREE when EnvIdle[i]=1 is sampled, in any FSM state. EnvIdle is ignored for FREE and HELD voices.
- Age: increments by 1 every cycle in HELD or RELEASING and saturates at 2^AGE_WIDTH-1. It is held at 0 in FREE.
- Simultaneous events on the same voice in EXEC: note-on assignment wins over an EnvIdle release. The voice ends HELD.

## Timing
- After reset:
  - All voices FREE.
  - Gate, Trigger, VoiceNote, Stolen = 0.
  - FSM in IDLE, so EventReady = 1 from the first cycle after reset.
- All outputs are registered.
- Handshake at edge N: EventReady = 0 after edge N. Gate/Trigger/VoiceNote/Stolen update at edge N+1. EventReady = 1 after edge N+1.
- Maximum throughput: one event per 2 cycles.
- Trigger and Stolen are high for exactly one cycle (after edge N+1), then 0.
- EnvIdle[i] sampled at edge M: voice i is FREE after edge M. It is usable by an event in EXEC at edge M+1.
- Reset low mid-EXEC: the latched event is discarded and nothing is applied.

## Test plan
- Reset, then note-on 60: EventReady goes 1,0,1. Two edges after the handshake: Gate=0001, Trigger=0001 for 1 cycle, VoiceNote[0]=60, Stolen=0.
- Note-ons 60,62,64,67, then note-off 62: Gate=1111, then 1101. Voice 1 keeps VoiceNote=62. Asserting EnvIdle[1] frees voice 1. The next note-on 70 lands in voice 1.
- With 4 voices HELD (60,62,64,67 in that order), note-on 72: voice 0 (oldest) is reassigned with VoiceNote=72. Trigger=0001 and Stolen=1 for one cycle. Gate remains 1111.
- Voices 0,1 RELEASING (voice 1 older) and voices 2,3 HELD, note-on 50: voice 1 is taken, Stolen=0.
- Note-on 60 while 60 is already HELD in voice 2: Trigger=0100 pulse, no other voice changes, age of voice 2 = 0.
- Note-off 99 (unmatched): EventReady cycles 1,0,1 and all outputs are unchanged. Reset held low during EXEC of a note-on: all outputs stay 0.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Note-event handshake bundle for the voice allocator.
// Master issues note-on/off events; slave accepts them.
interface voice_allocator_if #(
  parameter int NOTE_WIDTH = 7
);
  logic                  EventValid;
  logic                  EventReady;
  logic                  EventOn;
  logic [NOTE_WIDTH-1:0] EventNote;

  modport master (
    output EventValid,
    output EventOn,
    output EventNote,
    input  EventReady
  );

  modport slave (
    input  EventValid,
    input  EventOn,
    input  EventNote,
    output EventReady
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note events onto a pool of
// envelope voices with retrigger, free, release and steal policy.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 7,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                             Clock,
  input  logic                             Reset,
  voice_allocator_if.slave                 ev,
  input  logic [NUM_VOICES-1:0]            EnvIdle,
  output logic [NUM_VOICES-1:0]            Gate,
  output logic [NUM_VOICES-1:0]            Trigger,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] VoiceNote,
  output logic                             Stolen
);

  localparam int N  = NUM_VOICES;
  localparam int NW = NOTE_WIDTH;
  localparam int AW = AGE_WIDTH;
  localparam logic [AW-1:0] AGE_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } fsm_t;

  typedef enum logic [1:0] {
    V_FREE,
    V_HELD,
    V_REL
  } vst_t;

  fsm_t          fsm_q, fsm_n;
  vst_t          vst_q  [N];
  vst_t          vst_n  [N];
  logic [AW-1:0] age_q  [N];
  logic [AW-1:0] age_n  [N];
  logic [NW-1:0] note_q [N];
  logic [NW-1:0] note_n [N];

  logic          lat_on;
  logic [NW-1:0] lat_note;
  logic          ready_q, ready_n;
  logic [N-1:0]  gate_q, gate_n;
  logic [N-1:0]  trig_q, trig_n;
  logic          stolen_q, stolen_n;

  logic [N-1:0]  hit_oh, free_oh, rel_oh, held_oh;
  logic [N-1:0]  sel_oh;
  logic          steal;
  logic [AW-1:0] rel_age, held_age;
  logic          accept;

  assign accept = (fsm_q == S_IDLE) & ev.EventValid;

  // Candidate search: matching held note, first free, oldest releasing/held.
  always_comb begin
    hit_oh   = '0;
    free_oh  = '0;
    rel_oh   = '0;
    held_oh  = '0;
    rel_age  = '0;
    held_age = '0;
    for (int i = 0; i < N; i++) begin
      if (vst_q[i] == V_HELD && note_q[i] == lat_note && hit_oh == '0)
        hit_oh[i] = 1'b1;
      if (vst_q[i] == V_FREE && free_oh == '0)
        free_oh[i] = 1'b1;
      if (vst_q[i] == V_REL && (rel_oh == '0 || age_q[i] > rel_age)) begin
        rel_oh    = '0;
        rel_oh[i] = 1'b1;
        rel_age   = age_q[i];
      end
      if (vst_q[i] == V_HELD && (held_oh == '0 || age_q[i] > held_age)) begin
        held_oh    = '0;
        held_oh[i] = 1'b1;
        held_age   = age_q[i];
      end
    end
  end

  // Note-on target priority; stealing only when nothing else is left.
  always_comb begin
    sel_oh = '0;
    steal  = 1'b0;
    if (|hit_oh)
      sel_oh = hit_oh;
    else if (|free_oh)
      sel_oh = free_oh;
    else if (|rel_oh)
      sel_oh = rel_oh;
    else begin
      sel_oh = held_oh;
      steal  = 1'b1;
    end
  end

  // Controller and per-voice next state; assignment overrides EnvIdle.
  always_comb begin
    fsm_n    = fsm_q;
    trig_n   = '0;
    stolen_n = 1'b0;
    gate_n   = '0;
    unique case (fsm_q)
      S_IDLE: if (ev.EventValid) fsm_n = S_EXEC;
      S_EXEC: fsm_n = S_IDLE;
      default: fsm_n = S_IDLE;
    endcase
    ready_n = (fsm_n == S_IDLE);
    for (int i = 0; i < N; i++) begin
      vst_n[i]  = vst_q[i];
      note_n[i] = note_q[i];
      if (vst_q[i] == V_REL && EnvIdle[i])
        vst_n[i] = V_FREE;
    end
    if (fsm_q == S_EXEC) begin
      if (lat_on) begin
        trig_n   = sel_oh;
        stolen_n = steal & ~(|hit_oh);
        for (int i = 0; i < N; i++) begin
          if (sel_oh[i]) begin
            vst_n[i]  = V_HELD;
            note_n[i] = lat_note;
          end
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (hit_oh[i])
            vst_n[i] = V_REL;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      gate_n[i] = (vst_n[i] == V_HELD);
      if (vst_n[i] == V_FREE || trig_n[i])
        age_n[i] = '0;
      else if (age_q[i] != AGE_MAX)
        age_n[i] = age_q[i] + AW'(1);
      else
        age_n[i] = age_q[i];
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      fsm_q    <= S_IDLE;
      ready_q  <= 1'b1;
      lat_on   <= 1'b0;
      lat_note <= '0;
      gate_q   <= '0;
      trig_q   <= '0;
      stolen_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        vst_q[i]  <= V_FREE;
        age_q[i]  <= '0;
        note_q[i] <= '0;
      end
    end else begin
      fsm_q    <= fsm_n;
      ready_q  <= ready_n;
      gate_q   <= gate_n;
      trig_q   <= trig_n;
      stolen_q <= stolen_n;
      if (accept) begin
        lat_on   <= ev.EventOn;
        lat_note <= ev.EventNote;
      end
      for (int i = 0; i < N; i++) begin
        vst_q[i]  <= vst_n[i];
        age_q[i]  <= age_n[i];
        note_q[i] <= note_n[i];
      end
    end
  end

  // Pack per-voice notes onto the flat output bus.
  always_comb begin
    VoiceNote = '0;
    for (int i = 0; i < N; i++)
      VoiceNote[i*NW +: NW] = note_q[i];
  end

  assign ev.EventReady = ready_q;
  assign Gate          = gate_q;
  assign Trigger       = trig_q;
  assign Stolen        = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed events push
// expected outputs; a monitor checks them on each completion.
module tb_voice_allocator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  EnvIdle = '0;
  logic [3:0]  Gate, Trigger;
  logic [27:0] VoiceNote;
  logic        Stolen;

  voice_allocator_if #(.NOTE_WIDTH(7)) bus ();

  voice_allocator #(
    .NUM_VOICES(4), .NOTE_WIDTH(7), .AGE_WIDTH(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ev(bus.slave),
    .EnvIdle(EnvIdle), .Gate(Gate), .Trigger(Trigger),
    .VoiceNote(VoiceNote), .Stolen(Stolen)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       nm;
    logic [3:0]  g;
    logic [3:0]  t;
    logic        s;
    logic [27:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_rdy = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] vn(input logic [6:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Monitor: a rising EventReady marks a completed event.
  always @(negedge Clock) begin
    exp_t e;
    if (!prev_rdy && bus.EventReady === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_gate"}, 32'(Gate), 32'(e.g));
        chk({e.nm, "_trig"}, 32'(Trigger), 32'(e.t));
        chk({e.nm, "_stolen"}, 32'(Stolen), 32'(e.s));
        chk({e.nm, "_note"}, 32'(VoiceNote), 32'(e.v));
      end
    end
    prev_rdy = bus.EventReady;
  end

  task automatic push(input string nm, input logic [3:0] g,
                      input logic [3:0] t, input logic s,
                      input logic [27:0] v);
    exp_t e;
    e.nm = nm; e.g = g; e.t = t; e.s = s; e.v = v;
    sb.push_back(e);
  endtask

  task automatic send(input string nm, input logic on,
                      input logic [6:0] note, input logic [3:0] xidle,
                      input logic [3:0] g, input logic [3:0] t,
                      input logic s, input logic [27:0] v);
    push(nm, g, t, s, v);
    chk({nm, "_rdy_pre"}, 32'(bus.EventReady), 32'd1);
    bus.EventValid = 1'b1;
    bus.EventOn    = on;
    bus.EventNote  = note;
    @(negedge Clock);
    bus.EventValid = 1'b0;
    EnvIdle        = xidle;
    chk({nm, "_rdy_exec"}, 32'(bus.EventReady), 32'd0);
    @(negedge Clock);
    EnvIdle = '0;
    chk({nm, "_rdy_post"}, 32'(bus.EventReady), 32'd1);
    @(negedge Clock);
    chk({nm, "_pulse_end"}, 32'({Trigger, Stolen}), 32'd0);
  endtask

  task automatic idle_pulse(input logic [3:0] m);
    EnvIdle = m;
    @(negedge Clock);
    EnvIdle = '0;
    @(negedge Clock);
  endtask

  initial begin
    bus.EventValid = 1'b0;
    bus.EventOn    = 1'b0;
    bus.EventNote  = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    chk("rst_ready", 32'(bus.EventReady), 32'd1);
    chk("rst_gate", 32'(Gate), 32'd0);
    chk("rst_trig", 32'(Trigger), 32'd0);
    chk("rst_note", 32'(VoiceNote), 32'd0);
    chk("rst_stolen", 32'(Stolen), 32'd0);

    send("on60", 1, 60, 0, 4'b0001, 4'b0001, 0, vn(60, 0, 0, 0));
    send("on62", 1, 62, 0, 4'b0011, 4'b0010, 0, vn(60, 62, 0, 0));
    send("on64", 1, 64, 0, 4'b0111, 4'b0100, 0, vn(60, 62, 64, 0));
    send("on67", 1, 67, 0, 4'b1111, 4'b1000, 0, vn(60, 62, 64, 67));
    send("off62", 0, 62, 0, 4'b1101, 4'b0000, 0, vn(60, 62, 64, 67));
    idle_pulse(4'b0010);
    chk("idle1_gate", 32'(Gate), 32'(4'b1101));
    send("off60", 0, 60, 0, 4'b1100, 4'b0000, 0, vn(60, 62, 64, 67));
    send("on70_free", 1, 70, 0, 4'b1110, 4'b0010, 0, vn(60, 70, 64, 67));
    send("on72_rel", 1, 72, 0, 4'b1111, 4'b0001, 0, vn(72, 70, 64, 67));
    idle_pulse(4'b1111);
    chk("idle_held_gate", 32'(Gate), 32'(4'b1111));
    send("on74_steal", 1, 74, 0, 4'b1111, 4'b0100, 1, vn(72, 70, 74, 67));
    send("on67_retrig", 1, 67, 0, 4'b1111, 4'b1000, 0, vn(72, 70, 74, 67));
    send("on80_steal", 1, 80, 0, 4'b1111, 4'b0010, 1, vn(72, 80, 74, 67));
    send("off80", 0, 80, 0, 4'b1101, 4'b0000, 0, vn(72, 80, 74, 67));
    send("off67", 0, 67, 0, 4'b0101, 4'b0000, 0, vn(72, 80, 74, 67));
    send("on50_oldrel", 1, 50, 0, 4'b1101, 4'b1000, 0, vn(72, 80, 74, 50));
    send("off99", 0, 99, 0, 4'b1101, 4'b0000, 0, vn(72, 80, 74, 50));
    send("on55_vs_idle", 1, 55, 4'b0010, 4'b1111, 4'b0010, 0,
         vn(72, 55, 74, 50));

    push("rst_exec", 4'b0000, 4'b0000, 0, 28'd0);
    bus.EventValid = 1'b1;
    bus.EventOn    = 1'b1;
    bus.EventNote  = 7'd90;
    @(negedge Clock);
    bus.EventValid = 1'b0;
    Reset          = 1'b0;
    chk("rst_exec_rdy", 32'(bus.EventReady), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_exec_gate", 32'(Gate), 32'd0);
    chk("rst_exec_note", 32'(VoiceNote), 32'd0);

    send("on60_again", 1, 60, 0, 4'b0001, 4'b0001, 0, vn(60, 0, 0, 0));

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge Clock);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
